magnitude_compare_serial: RTL and testbench
===========================================

# magnitude_compare_serial

Parametrised, multi-cycle magnitude comparator that generalises our 2-bit combinational greater-than into a WIDTH-bit, signed/unsigned compare producing gt/eq/lt. Operands are examined MSB-first, DIGIT bits per cycle, with early termination on the first differing digit. It sits between the operand source and result consumer with valid/ready handshakes on both sides.

## Interface
- WIDTH, 8: operand width in bits; must be ≥ 2 and a multiple of DIGIT (elaboration error otherwise).
- DIGIT, 2: bits compared per cycle; 1 ≤ DIGIT ≤ WIDTH.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  operand pair offered.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  first operand.
- b  in  WIDTH  second operand.
- is_signed  in  1  1 = two's-complement compare, 0 = unsigned; sampled with operands.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result.
- gt, eq, lt  out  1 each  result flags; exactly one high when out_valid = 1, all 0 otherwise.
- cycles  out  $clog2(WIDTH/DIGIT+1)  number of BUSY cycles used by this result.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE: in_ready = 1. On in_valid & in_ready: capture a, b into shift registers; if is_signed, invert MSB of both captured values (offset-binary mapping, so unsigned compare is then correct); load digit counter with WIDTH/DIGIT; clear cycle count; go BUSY.
- BUSY: compare top DIGIT bits of the two shift registers; increment cycle count.
  - Top digit of a > top digit of b: result GT → DONE.
  - Top digit of a < top digit of b: result LT → DONE.
  - Equal, last digit: result EQ → DONE.
  - Equal, not last: shift both registers left by DIGIT, decrement counter, stay BUSY.
- DONE: out_valid = 1; gt/eq/lt/cycles held stable until out_valid & out_ready, then → IDLE, out_valid = 0 and flags cleared.
- No overlap: a new operand pair is only accepted in IDLE; in_valid outside IDLE is ignored (no capture).
- Operand and is_signed changes after capture have no effect on the result in progress.

## Timing
- Reset (rst high at an edge): state IDLE, out_valid = 0, gt = eq = lt = 0, cycles = 0. in_ready is gated by rst and is 0 while rst is high.
- Reset mid-operation (BUSY or DONE): operation abandoned with no result; outputs at reset values the cycle after the edge.
- Latency: accept at edge t0; k BUSY cycles, where k = index (1-based, MSB-first) of the first differing digit, or WIDTH/DIGIT if equal; out_valid high from edge t0+k.
- Minimum out_valid duration is 1 cycle (out_ready held high); IDLE follows at the next edge, accept possible at the edge after that. Minimum period is k+2 cycles.
- WIDTH == DIGIT: k = 1 always.
- All outputs are registered except in_ready (decoded from state and rst).

## Structure
- Package cmp_pkg: state enum (IDLE, BUSY, DONE); result enum (RES_LT, RES_EQ, RES_GT) used internally before decode to flags.
- Sub-module digit_compare (parameter DIGIT): combinational gt/eq of two DIGIT-bit slices; direct generalisation of the existing 2-bit greater-than, instantiated once.
- Top holds FSM, shift registers, counter, and output registers.

## Test plan
- WIDTH=8, DIGIT=2, unsigned, a=0xC3 b=0x3C → gt=1, cycles=1, out_valid one cycle after accept.
- Unsigned a=0x5A b=0x5A → eq=1, cycles=4; a=0x12 b=0x13 → lt=1, cycles=4.
- a=0x80 b=0x7F: is_signed=1 → lt=1, cycles=1; is_signed=0 → gt=1, cycles=1.
- a=0x12 b=0x13, out_ready held low 3 cycles after out_valid → lt, cycles stable, in_ready=0, and in_valid with a=0xFF during the hold is not captured; result consumed on 4th cycle, then IDLE.
- a=0x01 b=0x02, rst pulsed after 2 BUSY cycles → out_valid=0, flags 0, cycles=0; after release, a=0x02 b=0x01 → gt=1, cycles=4.
- WIDTH=4, DIGIT=4 instance, is_signed=1, a=0x9 b=0x9 → eq=1, cycles=1; a=0x9 (−7) b=0x1 → lt=1.

Source files
------------

// File: rtl/magnitude_compare_serial_pkg.sv
// Shared types for the serial magnitude comparator: FSM states, compare result
// encoding and its decode to one-hot {gt, eq, lt} flags.
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  typedef enum logic [1:0] {
    RES_LT,
    RES_EQ,
    RES_GT
  } res_e;

  // Returns {gt, eq, lt}
  function automatic logic [2:0] res_flags(input res_e r);
    case (r)
      RES_GT:  return 3'b100;
      RES_EQ:  return 3'b010;
      default: return 3'b001;
    endcase
  endfunction

endpackage

// File: rtl/digit_compare.sv
// Combinational greater-than / equal of two DIGIT-bit unsigned slices.
module digit_compare #(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  output logic             gt,
  output logic             eq
);

  assign gt = (a > b);
  assign eq = (a == b);

endmodule

// File: rtl/magnitude_compare_serial.sv
// MSB-first serial magnitude compare, DIGIT bits/cycle with early exit; result
// appears k cycles after accept and is held until out_ready, no new accept until then.
module magnitude_compare_serial
  import cmp_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [WIDTH-1:0]                    a,
  input  logic [WIDTH-1:0]                    b,
  input  logic                                is_signed,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic                                gt,
  output logic                                eq,
  output logic                                lt,
  output logic [$clog2(WIDTH/DIGIT+1)-1:0]    cycles
);

  localparam int CNT_W = $clog2(WIDTH/DIGIT+1);
  localparam int NDIG  = WIDTH / DIGIT;
  localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

  if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_param_check
    $error("magnitude_compare_serial: WIDTH must be >= 2 and a multiple of DIGIT");
  end

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_sh_q, a_sh_d;
  logic [WIDTH-1:0]  b_sh_q, b_sh_d;
  logic [CNT_W-1:0]  dcnt_q, dcnt_d;
  logic [CNT_W-1:0]  cyc_q, cyc_d;
  logic              out_valid_q, out_valid_d;
  logic [2:0]        flags_q, flags_d;

  logic              dig_gt, dig_eq;
  res_e              res;
  logic              finish;

  digit_compare #(.DIGIT(DIGIT)) u_digit_compare (
    .a  (a_sh_q[WIDTH-1 -: DIGIT]),
    .b  (b_sh_q[WIDTH-1 -: DIGIT]),
    .gt (dig_gt),
    .eq (dig_eq)
  );

  assign in_ready = (state_q == IDLE) && !rst;

  always_comb begin
    state_d     = state_q;
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    dcnt_d      = dcnt_q;
    cyc_d       = cyc_q;
    out_valid_d = out_valid_q;
    flags_d     = flags_q;
    res         = RES_EQ;
    finish      = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          // Flipping the sign bit maps two's complement onto offset binary,
          // so the digit loop below only ever does an unsigned compare.
          a_sh_d  = is_signed ? (a ^ MSB_MASK) : a;
          b_sh_d  = is_signed ? (b ^ MSB_MASK) : b;
          dcnt_d  = CNT_W'(NDIG);
          cyc_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        cyc_d = cyc_q + CNT_W'(1);
        if (dig_gt) begin
          res    = RES_GT;
          finish = 1'b1;
        end else if (!dig_eq) begin
          res    = RES_LT;
          finish = 1'b1;
        end else if (dcnt_q == CNT_W'(1)) begin
          res    = RES_EQ;
          finish = 1'b1;
        end else begin
          a_sh_d = a_sh_q << DIGIT;
          b_sh_d = b_sh_q << DIGIT;
          dcnt_d = dcnt_q - CNT_W'(1);
        end
        if (finish) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          flags_d     = res_flags(res);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          flags_d     = 3'b000;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      dcnt_q      <= '0;
      cyc_q       <= '0;
      out_valid_q <= 1'b0;
      flags_q     <= 3'b000;
    end else begin
      state_q     <= state_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      dcnt_q      <= dcnt_d;
      cyc_q       <= cyc_d;
      out_valid_q <= out_valid_d;
      flags_q     <= flags_d;
    end
  end

  assign out_valid = out_valid_q;
  assign gt        = flags_q[2];
  assign eq        = flags_q[1];
  assign lt        = flags_q[0];
  assign cycles    = cyc_q;

endmodule

// File: tb/tb_magnitude_compare_serial.sv
// Scoreboard bench: drivers push expected {flags, cycles, accept edge} on accept,
// a negedge monitor pops and compares when a result is handed over.
module tb_magnitude_compare_serial;

  typedef struct {
    logic [2:0] flags;  // {gt, eq, lt}
    int         cyc;
    int         t_acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic out_ready = 1'b1;

  // WIDTH=8, DIGIT=2 instance
  logic       in_valid8 = 1'b0, in_ready8, s8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       out_valid8, gt8, eq8, lt8;
  logic [2:0] cycles8;

  // WIDTH=4, DIGIT=4 instance
  logic       in_valid4 = 1'b0, in_ready4, s4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       out_valid4, gt4, eq4, lt4;
  logic [0:0] cycles4;

  exp_t q8[$];
  exp_t q4[$];
  int   edge_cnt = 0;
  int   n_checks = 0;
  int   n_pass   = 0;
  logic prev_v8 = 1'b0, prev_v4 = 1'b0;

  magnitude_compare_serial #(.WIDTH(8), .DIGIT(2)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .is_signed(s8), .out_valid(out_valid8), .out_ready(out_ready),
    .gt(gt8), .eq(eq8), .lt(lt8), .cycles(cycles8)
  );

  magnitude_compare_serial #(.WIDTH(4), .DIGIT(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .is_signed(s4), .out_valid(out_valid4), .out_ready(out_ready),
    .gt(gt4), .eq(eq4), .lt(lt4), .cycles(cycles4)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: latency on the rising edge of out_valid, content on handover.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_v8 <= 1'b0;
      prev_v4 <= 1'b0;
    end else begin
      if (out_valid8 && !prev_v8) begin
        if (q8.size() == 0) chk("w8_unexpected_result", 1, 0);
        else chk("w8_latency", edge_cnt - q8[0].t_acc, q8[0].cyc);
      end
      if (out_valid8 && out_ready && q8.size() > 0) begin
        e = q8.pop_front();
        chk("w8_flags", {gt8, eq8, lt8}, e.flags);
        chk("w8_cycles", cycles8, e.cyc);
      end
      if (out_valid4 && !prev_v4) begin
        if (q4.size() == 0) chk("w4_unexpected_result", 1, 0);
        else chk("w4_latency", edge_cnt - q4[0].t_acc, q4[0].cyc);
      end
      if (out_valid4 && out_ready && q4.size() > 0) begin
        e = q4.pop_front();
        chk("w4_flags", {gt4, eq4, lt4}, e.flags);
        chk("w4_cycles", cycles4, e.cyc);
      end
      prev_v8 <= out_valid8;
      prev_v4 <= out_valid4;
    end
  end

  task automatic send8(input logic [7:0] av, input logic [7:0] bv, input logic sg,
                       input logic [2:0] fl, input int k);
    int n = 0;
    exp_t e;
    @(negedge clk);
    while (!in_ready8 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready8) begin
      chk("w8_accept_timeout", 0, 1);
      return;
    end
    a8 = av; b8 = bv; s8 = sg; in_valid8 = 1'b1;
    @(posedge clk);
    #1;
    e.flags = fl; e.cyc = k; e.t_acc = edge_cnt;
    q8.push_back(e);
    in_valid8 = 1'b0;
  endtask

  task automatic send4(input logic [3:0] av, input logic [3:0] bv, input logic sg,
                       input logic [2:0] fl);
    int n = 0;
    exp_t e;
    @(negedge clk);
    while (!in_ready4 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready4) begin
      chk("w4_accept_timeout", 0, 1);
      return;
    end
    a4 = av; b4 = bv; s4 = sg; in_valid4 = 1'b1;
    @(posedge clk);
    #1;
    e.flags = fl; e.cyc = 1; e.t_acc = edge_cnt;
    q4.push_back(e);
    in_valid4 = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q8.size() > 0 || q4.size() > 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", q8.size() + q4.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid8, 0);
    chk("rst_flags", {gt8, eq8, lt8}, 3'b000);
    chk("rst_cycles", cycles8, 0);
    chk("rst_in_ready_gated", in_ready8, 0);
    rst = 1'b0;
    #1;
    chk("in_ready_after_rst", in_ready8, 1);

    // Unsigned / signed directed vectors, WIDTH=8 DIGIT=2
    send8(8'hC3, 8'h3C, 1'b0, 3'b100, 1);
    send8(8'h5A, 8'h5A, 1'b0, 3'b010, 4);
    send8(8'h12, 8'h13, 1'b0, 3'b001, 4);
    send8(8'h80, 8'h7F, 1'b1, 3'b001, 1);
    send8(8'h80, 8'h7F, 1'b0, 3'b100, 1);
    send8(8'hFF, 8'h01, 1'b1, 3'b001, 1);
    send8(8'h7F, 8'h80, 1'b1, 3'b100, 1);
    send8(8'h34, 8'h38, 1'b0, 3'b001, 3);
    send8(8'hF0, 8'hE0, 1'b1, 3'b100, 2);
    drain();

    // Backpressure: result held 3 cycles, in_valid during hold ignored
    out_ready = 1'b0;
    send8(8'h12, 8'h13, 1'b0, 3'b001, 4);
    n = 0;
    while (!out_valid8 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("hold_out_valid_seen", out_valid8, 1);
    for (int i = 0; i < 3; i++) begin
      chk("hold_flags", {gt8, eq8, lt8}, 3'b001);
      chk("hold_cycles", cycles8, 4);
      chk("hold_in_ready", in_ready8, 0);
      @(posedge clk);
      #1;
      if (i < 2) begin
        a8 = 8'hFF; b8 = 8'h00; s8 = 1'b0; in_valid8 = 1'b1;
      end else begin
        in_valid8 = 1'b0;
        out_ready = 1'b1;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    chk("hold_idle_out_valid", out_valid8, 0);
    chk("hold_idle_in_ready", in_ready8, 1);
    chk("hold_idle_flags", {gt8, eq8, lt8}, 3'b000);
    n = 0;
    repeat (4) begin
      @(negedge clk);
      if (out_valid8) n++;
    end
    chk("hold_no_capture", n, 0);

    // Reset mid-operation after 2 BUSY cycles
    @(negedge clk);
    a8 = 8'h01; b8 = 8'h02; s8 = 1'b0; in_valid8 = 1'b1;
    @(posedge clk);
    #1;
    in_valid8 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_out_valid", out_valid8, 0);
    chk("abort_flags", {gt8, eq8, lt8}, 3'b000);
    chk("abort_cycles", cycles8, 0);
    chk("abort_in_ready", in_ready8, 0);
    rst = 1'b0;
    send8(8'h02, 8'h01, 1'b0, 3'b100, 4);
    drain();

    // WIDTH == DIGIT instance: always one BUSY cycle
    send4(4'h9, 4'h9, 1'b1, 3'b010);
    send4(4'h9, 4'h1, 1'b1, 3'b001);
    send4(4'h9, 4'h1, 1'b0, 3'b100);
    drain();

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
